serial_full_adder: RTL
======================

Name: serial_full_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell and a registered carry.
- Performs the inverse arithmetic to the team's full-subtractor block: A + B + Cin, one bit per clock, LSB first.
- Used where area matters more than latency; also serves as the golden companion for subtractor checks, since (A - B) + B must return A.
- Start/busy/done handshake. Result registers are held stable between operations.

Parameters:
WIDTH, 8, operand and sum width in bits (must be >= 2)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request an addition; sampled on the rising edge
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while a bit-serial operation is in progress
done  output  1  one-cycle pulse; result is valid from this cycle onward
sum  output  WIDTH  registered result A+B+Cin, low WIDTH bits
cout  output  1  registered carry out of bit WIDTH-1
ovf  output  1  registered two's-complement signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter cleared. Reset release takes effect at the next clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, then
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0;
  - latch sign bits a[WIDTH-1] and b[WIDTH-1] for overflow;
  - go to RUN.
  Otherwise stay in IDLE.
- RUN, each cycle:
  - s = a_sh[0]^b_sh[0]^carry;
  - carry <= majority(a_sh[0], b_sh[0], carry);
  - a_sh and b_sh shift right one bit;
  - s shifts into the MSB of the internal accumulator acc;
  - cnt increments.
  - When cnt==WIDTH-1 (last bit), go to DONE.
- Transition RUN->DONE, on the same edge:
  - sum <= final acc value (including the last s bit);
  - cout <= final carry;
  - ovf <= (sign_a==sign_b) && (sum MSB != sign_a).
- DONE: done=1 for exactly this one cycle, busy=0.
  - If start=1, the new operation is accepted exactly as in IDLE and the state goes to RUN.
  - Otherwise go to IDLE.
- busy=1 only in RUN. done=1 only in DONE. Both are registered/state-decoded, glitch-free.
- Latency: start accepted at edge k; RUN occupies edges k+1 .. k+WIDTH; done is high in the cycle after edge k+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- Start while busy (RUN): ignored. The operation in flight is unaffected, and a, b and cin may change freely.
- Operand inputs matter only on the accepting edge.
- sum, cout and ovf change only on the RUN->DONE edge (or on reset). They hold the previous result throughout a following operation.
- The counter is wide enough for WIDTH-1 (clog2). There is no wrap-around, because it is reset on every accept.
- Reset asserted mid-RUN aborts the operation: all outputs return to 0 immediately and no done pulse is produced.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1).

Test Plan:
- WIDTH=8: reset, then start with a=8'h00, b=8'h00, cin=0 -> busy high for 8 cycles; done pulses in the 9th cycle after the accepting edge; sum=8'h00, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Also a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, ovf=0. Then a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
- Pulse start again 3 cycles into RUN with different operands -> ignored; result matches the first operands and exactly one done pulse occurs. Hold start=1 through DONE -> the second operation begins with no IDLE cycle and sum holds the first result until the second done.
- Drop rst_n asynchronously mid-RUN (between clock edges) -> busy, done, sum, cout and ovf are 0 immediately; no done pulse follows. After release, a new start completes correctly.
- Exhaustive sweep for WIDTH=4: all a, b, cin (512 cases) -> {cout,sum} equals a+b+cin. Cross-check with the subtractor: sum(a-b mod 16, b, 0) equals a.

Source files
------------

// File: rtl/serial_full_adder_if.sv
// Operand/handshake bundle for the bit-serial adder: the requester drives start
// and operands; the adder returns busy/done and the registered result.
interface serial_full_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry, LSB first,
// with a start/busy/done handshake and result registers held between operations.
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_full_adder_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_bit;
    logic             s_bit;

    assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        accept   = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = bus.start;
            end
            StRun: begin
                carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                          (b_sh_q[0] & carry_q);
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StDone;
                    sum_d   = acc_d;
                    cout_d  = carry_d;
                    // The final sum bit is the result MSB.
                    ovf_d   = (sign_a_q == sign_b_q) && (s_bit != sign_a_q);
                end
            end
            StDone: begin
                accept = bus.start;
                if (!bus.start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d  = StRun;
            a_sh_d   = bus.a;
            b_sh_d   = bus.b;
            carry_d  = bus.cin;
            acc_d    = '0;
            cnt_d    = '0;
            sign_a_d = bus.a[WIDTH-1];
            sign_b_d = bus.b[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.done));

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);

    a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == StRun && last_bit) |=> $stable({sum_q, cout_q, ovf_q}));
endmodule
